// File: rtl/serial_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_rx_param                                                 |
// | Purpose  : One-bit-per-clock serial frame receiver (start, LSB-first data, |
// |            optional parity, 1-2 stop bits) with a one-deep holding register|
// |            and error pulses. Define SERIAL_RX_ERR_CNT_EN to add the        |
// |            saturating error counter (i_err_clr / o_err_cnt).               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_rx_param #(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_overrun
`ifdef SERIAL_RX_ERR_CNT_EN
  ,
  input  logic              i_err_clr,
  output logic [7:0]        o_err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(DATA_W - 1);
  localparam logic             c_last_stop = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
    S_PAR      = 3'd2,
    S_STOP     = 3'd3,
    S_ERR_WAIT = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_stop_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_ok;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_par_ok;

  always_comb begin
    w_par_ok = 1'b1;
    if (PARITY == 1)      w_par_ok = (^r_shift) ^ i_data;
    else if (PARITY == 2) w_par_ok = ~((^r_shift) ^ i_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_ok     <= 1'b1;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      if (r_valid && i_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!i_data) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shift in from the top
          r_shift   <= {i_data, r_shift[DATA_W-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par_ok   <= 1'b1;
            r_state    <= (PARITY == 0) ? S_STOP : S_PAR;
          end
        end
        S_PAR: begin
          r_par_ok <= w_par_ok;
          r_state  <= S_STOP;
        end
        S_STOP: begin
          if (!i_data) begin
            r_frame_err <= 1'b1;
            r_state     <= S_ERR_WAIT;
          end else if (r_stop_cnt == c_last_stop) begin
            r_state <= S_IDLE;
            if (!r_par_ok) begin
              r_parity_err <= 1'b1;
            end else if (r_valid && !i_ready) begin
              r_overrun <= 1'b1;
            end else begin
              // also covers the same-edge consume-and-replace case
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end
          end else begin
            r_stop_cnt <= r_stop_cnt + 1'b1;
          end
        end
        S_ERR_WAIT: begin
          if (i_data) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_parity_err = r_parity_err;
  assign o_frame_err  = r_frame_err;
  assign o_overrun    = r_overrun;

`ifdef SERIAL_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (i_err_clr) begin
      r_err_cnt <= 8'd0;
    end else if ((r_parity_err || r_frame_err || r_overrun) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_param.sv
`default_nettype none
// Scoreboarded bench for serial_rx_param: a default instance and a 7-bit /
// even-parity / two-stop instance, directed frames followed by random frames.
module tb_serial_rx_param;

  localparam int EV_DATA = 1, EV_PERR = 2, EV_FERR = 3, EV_OVR = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line [2];
  logic       rdy  [2];
  logic [7:0] o_data0;
  logic [6:0] o_data1;
  logic       o_valid0, o_valid1;
  logic       perr0, perr1, ferr0, ferr1, ovr0, ovr1;
`ifdef SERIAL_RX_ERR_CNT_EN
  logic       clr;
  logic [7:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int q0[$];
  int q1[$];
  bit m_full [2];
  bit pv [2];
  bit pc [2];
  int last_data [2];

  always #5 clk = ~clk;

  serial_rx_param u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_data(line[0]), .o_data(o_data0), .o_valid(o_valid0),
    .i_ready(rdy[0]), .o_parity_err(perr0), .o_frame_err(ferr0), .o_overrun(ovr0)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .i_err_clr(clr), .o_err_cnt(cnt0)
`endif
  );

  serial_rx_param #(.DATA_W(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_data(line[1]), .o_data(o_data1), .o_valid(o_valid1),
    .i_ready(rdy[1]), .o_parity_err(perr1), .o_frame_err(ferr1), .o_overrun(ovr1)
`ifdef SERIAL_RX_ERR_CNT_EN
    , .i_err_clr(1'b0), .o_err_cnt(cnt1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int ev);
    if (d == 0) q0.push_back(ev);
    else        q1.push_back(ev);
  endtask

  task automatic expect_ev(input int d, input int got);
    int e;
    bit empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected event: got 0x%0h expected none", d, got);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("dut%0d event", d), got, e);
      if ((e >> 10) == EV_DATA) last_data[d] = e & 1023;
    end
  endtask

  // Monitor: turns each observed output change into an event for the scoreboard
  task automatic mon(input int d, input bit v, input int data, input bit pe, input bit fe, input bit ov);
    bit newf;
    newf = v && (!pv[d] || pc[d]);
    if (newf) expect_ev(d, (EV_DATA << 10) | data);
    if (pe)   expect_ev(d, EV_PERR << 10);
    if (fe)   expect_ev(d, EV_FERR << 10);
    if (ov)   expect_ev(d, EV_OVR << 10);
    if (v && !newf) chk($sformatf("dut%0d held data", d), data, last_data[d]);
    pv[d] = v;
    pc[d] = v && rdy[d];
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      pv[0] = 1'b0; pv[1] = 1'b0; pc[0] = 1'b0; pc[1] = 1'b0;
    end else begin
      mon(0, o_valid0, int'(o_data0), perr0, ferr0, ovr0);
      mon(1, o_valid1, int'(o_data1), perr1, ferr1, ovr1);
    end
  end

  // Reference model: what each DUT must report at the edge just being driven.
  task automatic model(input int d, input bit r, input int ev, input int payload);
    if (ev == EV_DATA) begin
      if (m_full[d] && !r) push(d, EV_OVR << 10);
      else begin
        push(d, (EV_DATA << 10) | payload);
        m_full[d] = 1'b1;
      end
    end else begin
      if (ev == EV_PERR) push(d, EV_PERR << 10);
      if (ev == EV_FERR) push(d, EV_FERR << 10);
      if (m_full[d] && r) m_full[d] = 1'b0;
    end
  endtask

  task automatic step(input int d, input bit b, input bit r, input int ev, input int payload);
    int o;
    o = 1 - d;
    line[d] = b; rdy[d] = r;
    line[o] = 1'b1; rdy[o] = 1'b1;
    model(d, r, ev, payload);
    model(o, 1'b1, 0, 0);
    @(posedge clk); #1;
  endtask

  // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the completing edge
  function automatic bit pick(input int mode, input bit last);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom % 2);
      default: return last;
    endcase
  endfunction

  task automatic send_frame(input int d, input int payload, input bit bad_par,
                            input int bad_stop, input int hold, input int gap, input int mode);
    int w, s, ones;
    bit pbit, done;
    w = (d == 0) ? 8 : 7;
    s = (d == 0) ? 1 : 2;
    payload = payload & ((1 << w) - 1);
    ones = $countones(payload);
    pbit = (d == 0) ? (ones % 2 == 0) : (ones % 2 == 1);
    if (bad_par) pbit = ~pbit;
    step(d, 1'b0, pick(mode, 1'b0), 0, 0);
    for (int i = 0; i < w; i++) step(d, payload[i], pick(mode, 1'b0), 0, 0);
    step(d, pbit, pick(mode, 1'b0), 0, 0);
    done = 1'b0;
    for (int k = 1; k <= s; k++) begin
      if (!done) begin
        if (bad_stop == k) begin
          step(d, 1'b0, pick(mode, 1'b1), EV_FERR, 0);
          repeat (hold) step(d, 1'b0, pick(mode, 1'b0), 0, 0);
          step(d, 1'b1, pick(mode, 1'b0), 0, 0);
          done = 1'b1;
        end else begin
          step(d, 1'b1, pick(mode, k == s), (k == s) ? (bad_par ? EV_PERR : EV_DATA) : 0, payload);
        end
      end
    end
    repeat (gap) step(d, 1'b1, pick(mode, 1'b1), 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " o_data0"}, int'(o_data0), 0);
    chk({tag, " o_valid0"}, int'(o_valid0), 0);
    chk({tag, " pulses0"}, int'({perr0, ferr0, ovr0}), 0);
    chk({tag, " o_valid1"}, int'(o_valid1), 0);
`ifdef SERIAL_RX_ERR_CNT_EN
    chk({tag, " err_cnt"}, int'(cnt0), 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    line[0] = 1'b1; line[1] = 1'b1; rdy[0] = 1'b1; rdy[1] = 1'b1;
`ifdef SERIAL_RX_ERR_CNT_EN
    clr = 1'b0;
`endif
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed frames on the default instance
    send_frame(0, 'hA5, 1'b0, 0, 0, 2, 1);
    send_frame(0, 'hA5, 1'b1, 0, 0, 0, 1);
    send_frame(0, 'h3C, 1'b0, 0, 0, 2, 1);
    send_frame(0, 'hA5, 1'b0, 1, 4, 0, 1);
    send_frame(0, 'h5A, 1'b0, 0, 0, 2, 1);
    send_frame(0, 'h11, 1'b0, 0, 0, 0, 0);
    send_frame(0, 'h22, 1'b0, 0, 0, 0, 0);
    send_frame(0, 'h22, 1'b0, 0, 0, 2, 3);
    send_frame(0, 'hA5, 1'b1, 1, 1, 1, 1);

    // Seven-bit, even parity, two stop bits
    send_frame(1, 'h55, 1'b0, 0, 0, 2, 1);
    send_frame(1, 'h55, 1'b0, 2, 2, 1, 1);
    send_frame(1, 'h2A, 1'b0, 1, 0, 1, 1);

    // Reset mid-frame after four data bits
    step(0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, i[0], 1'b1, 0, 0);
    #2;
    rst_n = 1'b0;
    line[0] = 1'b1;
    m_full[0] = 1'b0; m_full[1] = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(0, 'hC3, 1'b0, 0, 0, 2, 1);

    // Random frames on both instances
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        int bs;
        bs = ($urandom % 6 == 0) ? int'($urandom_range(1, d + 1)) : 0;
        send_frame(d, int'($urandom % 256), ($urandom % 5 == 0), bs,
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      end
      repeat (3) step(d, 1'b1, 1'b1, 0, 0);
    end

`ifdef SERIAL_RX_ERR_CNT_EN
    for (int n = 0; n < 300; n++) send_frame(0, n, 1'b1, 0, 0, 0, 1);
    repeat (3) step(0, 1'b1, 1'b1, 0, 0);
    chk("err_cnt saturated", int'(cnt0), 255);
    clr = 1'b1;
    step(0, 1'b1, 1'b1, 0, 0);
    clr = 1'b0;
    chk("err_cnt cleared", int'(cnt0), 0);
    send_frame(0, 'h12, 1'b1, 0, 0, 0, 1);
    send_frame(0, 'h34, 1'b1, 0, 0, 3, 1);
    chk("err_cnt two errors", int'(cnt0), 2);
`endif

    repeat (4) step(0, 1'b1, 1'b1, 0, 0);
    chk("dut0 pending events", q0.size(), 0);
    chk("dut1 pending events", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
